// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed FND scan controller: steps the external nibble mux select, decodes the returned
// nibble to active-low segments and strobes one active-low digit enable per slot, with a blank gap.
// Optional leading-zero suppression is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_ctrl #(
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned NUM_DIGITS   = 8
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   input  logic [3:0] i_y,
   input  logic [7:0] i_dp,
   output logic [2:0] o_sel,
   output logic [7:0] o_digit_n,
   output logic [7:0] o_seg_n,
   output logic       o_frame_done
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam logic [2:0]  SEL_MSB = 3'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      sel_q, sel_d;
   logic [7:0]      digit_q, digit_d;
   logic [7:0]      seg_q, seg_d;
   logic            frame_q, frame_d;
   logic            lz_dark;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      sel_d   = sel_q;
      frame_d = 1'b0;
      case (state_q)
         ST_OFF: begin
            cnt_d = '0;
            if (i_en) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (cnt_q == CW'(TICK_DIV - 1)) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               sel_d   = (sel_q == '0) ? SEL_MSB : sel_q - 3'd1;
               frame_d = (sel_q == '0);
            end
         end
         default: state_d = ST_OFF;
      endcase
      if (!i_en) begin
         state_d = ST_OFF;
         cnt_d   = '0;
         sel_d   = SEL_MSB;
         frame_d = 1'b0;
      end
   end

   // Segments decode the nibble for the select currently on the mux pins; the stale first blank
   // cycle after a select change is hidden by the gap.
   always_comb begin
      seg_d   = (state_d == ST_OFF) ? '1 : {~i_dp[sel_q], seg7(i_y)};
      digit_d = '1;
      if (state_d == ST_SHOW && !lz_dark) digit_d[sel_d] = 1'b0;
   end

`ifdef FND_LEADING_ZERO_BLANK_EN
   logic nz_q, nz_d;

   always_comb begin
      nz_d = nz_q;
      if (state_d == ST_BLANK && cnt_d == '0 && sel_d == SEL_MSB) nz_d = 1'b0;
      if (state_q == ST_BLANK && state_d == ST_SHOW && i_y != '0) nz_d = 1'b1;
      if (state_d == ST_OFF) nz_d = 1'b0;
      lz_dark = (i_y == '0) && !nz_d && (sel_q != '0) && !i_dp[sel_q];
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) nz_q <= 1'b0;
      else            nz_q <= nz_d;
   end
`else
   assign lz_dark = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         sel_q   <= SEL_MSB;
         digit_q <= '1;
         seg_q   <= '1;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         digit_q <= digit_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end

   assign o_sel        = sel_q;
   assign o_digit_n    = digit_q;
   assign o_seg_n      = seg_q;
   assign o_frame_done = frame_q;

endmodule
